arbitro_serializador: RTL and testbench
=======================================

// Module: arbitro_serializador
// PURPOSE
//  Round-robin scheduler sharing one paralelo_serial lane among 4 byte FIFOs.
//  Runs in the clk_4f (byte) domain.
//  - Picks an eligible FIFO and emits a header byte carrying its lane id.
//  - Then pops up to BURST_MAX bytes from that FIFO into data_out/valid_out.
//  When valid_out=0 the serializer sends its idle/COM symbol; this block
//  never drives idles itself.
// PARAMETERS
//  BURST_MAX  4      max payload bytes per grant (1..15)
//  HDR_BASE   8'hF0  header byte = HDR_BASE | {6'b0, lane_id}
// PORTS
//  clk_4f      in   1     byte clock, all logic on posedge
//  reset       in   1     synchronous, active-high
//  lane_en     in   4     per-lane enable; sampled only at arbitration
//  fifo_empty  in   4     per-lane FIFO empty flag
//  fifo_data   in   32    show-ahead FIFO heads; lane i = [8i+7:8i]
//  pop         out  4     one-hot read strobe to FIFO (combinational)
//  data_out    out  8     byte to paralelo_serial data_in
//  valid_out   out  1     qualifies data_out; to paralelo_serial valid_in
//  grant_id    out  2     lane currently/last granted
//  busy        out  1     1 while state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE, ptr=0, cnt=0, data_out=8'h00, valid_out=0,
//   grant_id=0, busy=0, pop=0. Reset overrides all, including mid-burst;
//   any partial burst is abandoned with no more pops.
//  Eligible lane i: lane_en[i] & ~fifo_empty[i].
//  Outputs data_out/valid_out/grant_id are registered. pop = f(state, regs, fifo_empty).
//  States:
//   IDLE: pop=0, valid_out<=0, data_out<=0.
//    - No eligible lane: stay in IDLE.
//    - Eligible lane: grant g = first eligible lane searching ptr, ptr+1, ... (mod 4).
//      At that edge: grant_id<=g, data_out<=HDR_BASE|g, valid_out<=1,
//      cnt<=0, state<=BURST.
//   BURST: pop[grant_id] = ~fifo_empty[grant_id]; other bits 0.
//    - Not empty: data_out<=fifo_data[grant_id], valid_out<=1, cnt<=cnt+1.
//      If cnt==BURST_MAX-1: state<=IDLE, ptr<=grant_id+1 (wraps 3->0).
//    - Empty: valid_out<=0, state<=IDLE, ptr<=grant_id+1 (burst ends short;
//      header-only burst is legal).
//  Latency: request seen at edge N -> header valid after N; first payload
//   after N+1; each pop edge puts that byte on data_out after the same edge.
//  Gap: at least one valid_out=0 cycle between bursts (the IDLE cycle).
//  Payload count never exceeds BURST_MAX.
//  lane_en dropping mid-burst does not stop the burst.
//  fifo_empty rising mid-burst ends the burst.
//  cnt width = $clog2(BURST_MAX+1).
// TESTING
//  1 reset=1 for 2 cycles, lanes full -> valid_out=0, pop=0, data_out=00,
//    busy=0 throughout.
//  2 Only lane 2, 6 bytes A0..A5, BURST_MAX=4 -> F2,A0,A1,A2,A3, idle, then
//    F2,A4,A5, idle.
//  3 All lanes non-empty, ptr=0 -> header order F0,F1,F2,F3,F0; each burst
//    4 bytes; pop one-hot and only in BURST.
//  4 Lane 1 holds 1 byte (55) -> F1,55, valid_out=0 next cycle; ptr->2.
//  5 lane_en=4'b1011, all full -> lane 2 never granted; order F0,F1,F3,F0.
//  6 reset asserted on 2nd payload byte of a burst -> next cycle
//    valid_out=0, pop=0, state IDLE; after release first grant is lane 0.

Source files
------------

// File: rtl/arbitro_serializador.sv
// Round-robin scheduler that shares one serializer lane among four byte FIFOs.
// Each grant emits a header byte carrying the lane id, then up to BURST_MAX payload bytes.
module arbitro_serializador #(
  parameter int unsigned BURST_MAX = 4,
  parameter logic [7:0]  HDR_BASE  = 8'hF0
) (
  input  logic        i_clk_4f,
  input  logic        i_reset,
  input  logic [3:0]  i_lane_en,
  input  logic [3:0]  i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic [3:0]  o_pop,
  output logic [7:0]  o_data_out,
  output logic        o_valid_out,
  output logic [1:0]  o_grant_id,
  output logic        o_busy
);

  localparam int unsigned         CNT_W    = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_ptr;
  logic [1:0]         w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         r_data_out;
  logic [7:0]         w_data_nxt;
  logic               r_valid_out;
  logic               w_valid_nxt;
  logic [1:0]         r_grant_id;
  logic [1:0]         w_grant_nxt;

  logic [3:0]         w_elig;
  logic [3:0]         w_rot;
  logic [1:0]         w_off;
  logic [1:0]         w_sel;
  logic               w_found;
  logic [7:0]         w_head;
  logic               w_head_empty;
  logic [3:0]         w_pop;
  logic               w_busy;

  assign w_elig  = i_lane_en & ~i_fifo_empty;
  // Bit 0 of w_rot is the lane at r_ptr, so the lowest set bit is the next lane in rotation.
  assign w_rot   = {w_elig[r_ptr + 2'd3], w_elig[r_ptr + 2'd2], w_elig[r_ptr + 2'd1], w_elig[r_ptr]};
  assign w_found = |w_rot;
  assign w_sel   = r_ptr + w_off;

  assign w_head       = i_fifo_data[{r_grant_id, 3'b000} +: 8];
  assign w_head_empty = i_fifo_empty[r_grant_id];

  // Priority encoder over the rotated eligibility vector
  always_comb begin
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk_4f) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= '0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_grant_id  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_out  <= w_data_nxt;
      r_valid_out <= w_valid_nxt;
      r_grant_id  <= w_grant_nxt;
    end
  end

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data_out;
    w_valid_nxt = r_valid_out;
    w_grant_nxt = r_grant_id;
    case (r_state)
      S_IDLE: begin
        // A burst that just ran to BURST_MAX leaves valid high; hold off one cycle so bursts never touch.
        if (w_found && !r_valid_out) begin
          w_grant_nxt = w_sel;
          w_data_nxt  = HDR_BASE | {6'b000000, w_sel};
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_BURST;
        end else begin
          w_data_nxt  = 8'h00;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        if (!w_head_empty) begin
          w_data_nxt  = w_head;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = r_grant_id + 2'd1;
          end else begin
            w_state_nxt = S_BURST;
          end
        end else begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_grant_id + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_data_nxt  = 8'h00;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // FIFO read strobe and busy flag; pop is held off while reset is asserted
  always_comb begin
    w_pop  = 4'b0000;
    w_busy = (r_state == S_BURST);
    if ((r_state == S_BURST) && !w_head_empty && !i_reset) begin
      w_pop[r_grant_id] = 1'b1;
    end else begin
      w_pop = 4'b0000;
    end
  end

  assign o_pop       = w_pop;
  assign o_busy      = w_busy;
  assign o_data_out  = r_data_out;
  assign o_valid_out = r_valid_out;
  assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_arbitro_serializador.sv
// Directed bench for arbitro_serializador: show-ahead FIFO model per lane and
// hand-built expected byte streams checked cycle by cycle.
module tb_arbitro_serializador;

  localparam int BURST_MAX = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  lane_en;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  grant_id;
  logic        busy;

  arbitro_serializador #(.BURST_MAX(BURST_MAX), .HDR_BASE(8'hF0)) dut (
    .i_clk_4f     (clk),
    .i_reset      (reset),
    .i_lane_en    (lane_en),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_pop        (pop),
    .o_data_out   (data_out),
    .o_valid_out  (valid_out),
    .o_grant_id   (grant_id),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4][32];
  int         rd [4];
  int         wr [4];
  logic [3:0] last_pop;

  logic [8:0] ev [64];
  logic [3:0] ep [64];
  logic       eb [64];
  logic [1:0] eg [64];
  int         n;
  int         cur_lane;
  int         cur_cnt;

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]       = (rd[i] == wr[i]);
      fifo_data[8*i +: 8] = mem[i][rd[i] % 32];
    end
  endtask

  task automatic fifo_clear();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    refresh();
  endtask

  task automatic fifo_push(input int l, input logic [7:0] b);
    mem[l][wr[l]] = b;
    wr[l] = wr[l] + 1;
    refresh();
  endtask

  // One clock: capture the strobe the DUT presents at the edge, then let the FIFO model react.
  task automatic tick();
    #1;
    last_pop = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (last_pop[i] && (rd[i] != wr[i])) rd[i] = rd[i] + 1;
    end
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_clear();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic exp_clear();
    n = 0;
    cur_lane = 0;
    cur_cnt = 0;
  endtask

  task automatic push_hdr(input int l);
    ev[n] = {1'b1, 8'hF0 | 8'(l)};
    ep[n] = 4'b0000;
    eb[n] = 1'b1;
    eg[n] = 2'(l);
    cur_lane = l;
    cur_cnt = 0;
    n = n + 1;
  endtask

  task automatic push_pay(input logic [7:0] b);
    cur_cnt = cur_cnt + 1;
    ev[n] = {1'b1, b};
    ep[n] = 4'b0001 << cur_lane;
    eb[n] = (cur_cnt < BURST_MAX);
    eg[n] = 2'(cur_lane);
    n = n + 1;
  endtask

  task automatic push_idle();
    ev[n] = 9'h000;
    ep[n] = 4'b0000;
    eb[n] = 1'b0;
    eg[n] = 2'(cur_lane);
    n = n + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int l = 0; l < 4; l++) fifo_push(l, 8'h33);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b exp 0", c, valid_out); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data[%0d] got %h exp 00", c, data_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", c, busy); end
      checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop[%0d] got %b exp 0000", c, pop); end
    end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    reset = 1'b0;
  endtask

  task automatic test_single_lane();
    do_reset();
    for (int j = 0; j < 6; j++) fifo_push(2, 8'hA0 + 8'(j));
    exp_clear();
    push_hdr(2);
    for (int j = 0; j < 4; j++) push_pay(8'hA0 + 8'(j));
    push_idle();
    push_hdr(2);
    push_pay(8'hA4);
    push_pay(8'hA5);
    push_idle();
    for (int k = 0; k < n; k++) begin
      tick();
      checks++; if (valid_out !== ev[k][8]) begin errors++; $display("FAIL single_valid[%0d] got %b exp %b", k, valid_out, ev[k][8]); end
      if (ev[k][8]) begin
        checks++; if (data_out !== ev[k][7:0]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", k, data_out, ev[k][7:0]); end
      end
      checks++; if (last_pop !== ep[k]) begin errors++; $display("FAIL single_pop[%0d] got %b exp %b", k, last_pop, ep[k]); end
      checks++; if (busy !== eb[k]) begin errors++; $display("FAIL single_busy[%0d] got %b exp %b", k, busy, eb[k]); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int j = 0; j < 4; j++) fifo_push(l, 8'((l + 1) * 16 + j));
    for (int j = 4; j < 8; j++) fifo_push(0, 8'(16 + j));
    exp_clear();
    for (int l = 0; l < 4; l++) begin
      push_hdr(l);
      for (int j = 0; j < 4; j++) push_pay(8'((l + 1) * 16 + j));
      push_idle();
    end
    push_hdr(0);
    for (int j = 4; j < 8; j++) push_pay(8'(16 + j));
    push_idle();
    for (int k = 0; k < n; k++) begin
      tick();
      checks++; if (valid_out !== ev[k][8]) begin errors++; $display("FAIL rr_valid[%0d] got %b exp %b", k, valid_out, ev[k][8]); end
      if (ev[k][8]) begin
        checks++; if (data_out !== ev[k][7:0]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, data_out, ev[k][7:0]); end
        checks++; if (grant_id !== eg[k]) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grant_id, eg[k]); end
      end
      checks++; if (last_pop !== ep[k]) begin errors++; $display("FAIL rr_pop[%0d] got %b exp %b", k, last_pop, ep[k]); end
      checks++; if (busy !== eb[k]) begin errors++; $display("FAIL rr_busy[%0d] got %b exp %b", k, busy, eb[k]); end
    end
  endtask

  task automatic test_short_burst();
    do_reset();
    fifo_push(1, 8'h55);
    exp_clear();
    push_hdr(1);
    push_pay(8'h55);
    push_idle();
    push_hdr(2);
    push_pay(8'h77);
    push_idle();
    push_hdr(1);
    push_pay(8'h66);
    push_idle();
    for (int k = 0; k < n; k++) begin
      // Once lane 1 drains, refill lanes 1 and 2: the pointer must now favour lane 2.
      if (k == 3) begin
        fifo_push(1, 8'h66);
        fifo_push(2, 8'h77);
      end
      tick();
      checks++; if (valid_out !== ev[k][8]) begin errors++; $display("FAIL short_valid[%0d] got %b exp %b", k, valid_out, ev[k][8]); end
      if (ev[k][8]) begin
        checks++; if (data_out !== ev[k][7:0]) begin errors++; $display("FAIL short_data[%0d] got %h exp %h", k, data_out, ev[k][7:0]); end
      end
      checks++; if (last_pop !== ep[k]) begin errors++; $display("FAIL short_pop[%0d] got %b exp %b", k, last_pop, ep[k]); end
      checks++; if (busy !== eb[k]) begin errors++; $display("FAIL short_busy[%0d] got %b exp %b", k, busy, eb[k]); end
    end
  endtask

  task automatic test_lane_enable();
    do_reset();
    lane_en = 4'b1011;
    for (int l = 0; l < 4; l++)
      for (int j = 0; j < 4; j++) fifo_push(l, 8'((l + 1) * 16 + j));
    for (int j = 4; j < 8; j++) fifo_push(0, 8'(16 + j));
    exp_clear();
    for (int s = 0; s < 4; s++) begin
      int l;
      l = (s == 0) ? 0 : (s == 1) ? 1 : (s == 2) ? 3 : 0;
      push_hdr(l);
      for (int j = 0; j < 4; j++) push_pay(8'((l + 1) * 16 + ((s == 3) ? j + 4 : j)));
      push_idle();
    end
    for (int k = 0; k < n; k++) begin
      tick();
      checks++; if (valid_out !== ev[k][8]) begin errors++; $display("FAIL en_valid[%0d] got %b exp %b", k, valid_out, ev[k][8]); end
      if (ev[k][8]) begin
        checks++; if (data_out !== ev[k][7:0]) begin errors++; $display("FAIL en_data[%0d] got %h exp %h", k, data_out, ev[k][7:0]); end
      end
      checks++; if (last_pop !== ep[k]) begin errors++; $display("FAIL en_pop[%0d] got %b exp %b", k, last_pop, ep[k]); end
    end
    lane_en = 4'b1111;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int j = 0; j < 4; j++) fifo_push(l, 8'((l + 1) * 16 + j));
    tick();
    checks++; if (data_out !== 8'hF0 || valid_out !== 1'b1) begin errors++; $display("FAIL midrst_hdr got %b/%h exp 1/f0", valid_out, data_out); end
    tick();
    checks++; if (data_out !== 8'h10 || valid_out !== 1'b1) begin errors++; $display("FAIL midrst_pay1 got %b/%h exp 1/10", valid_out, data_out); end
    reset = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    reset = 1'b0;
    #1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL midrst_pop got %b exp 0000", pop); end
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 8'hF0) begin errors++; $display("FAIL midrst_regrant got %b/%h exp 1/f0", valid_out, data_out); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL midrst_grant got %0d exp 0", grant_id); end
  endtask

  initial begin
    reset   = 1'b1;
    lane_en = 4'b1111;
    fifo_clear();
    test_reset();
    test_single_lane();
    test_round_robin();
    test_short_burst();
    test_lane_enable();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
